// File: rtl/demux_1_to_2_buf.sv
// Buffered 1-to-2 demux: each output has its own 2-entry FIFO; words appear the cycle after acceptance.
// in_ready depends only on the registered occupancy of the selected FIFO, so there is no path from outX_ready.

module demux_fifo2 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);
  logic [1:0]       occ;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             pop;

  assign valid = (occ != 2'd0);
  assign full  = (occ == 2'd2);
  assign data  = head;
  assign pop   = valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      case (occ)
        2'd0: if (push) begin
          head <= push_data;
          occ  <= 2'd1;
        end
        2'd1: begin
          // Push and pop together: the incoming word becomes the new head.
          if (push && pop) begin
            head <= push_data;
          end else if (push) begin
            tail <= push_data;
            occ  <= 2'd2;
          end else if (pop) begin
            occ <= 2'd0;
          end
        end
        2'd2: if (pop) begin
          head <= tail;
          occ  <= 2'd1;
        end
        default: occ <= 2'd0;
      endcase
      if (pop) cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

module demux_1_to_2_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [CNT_W-1:0] out0_cnt,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] out1_cnt
);
  logic full0;
  logic full1;
  logic accept;

  // A full FIFO refuses input even if its head pops this cycle: one bubble, no ready chain.
  assign in_ready = sel ? ~full1 : ~full0;
  assign accept   = in_valid & in_ready;

  demux_fifo2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept & ~sel),
    .push_data (in_data),
    .ready     (out0_ready),
    .valid     (out0_valid),
    .data      (out0_data),
    .cnt       (out0_cnt),
    .full      (full0)
  );

  demux_fifo2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept & sel),
    .push_data (in_data),
    .ready     (out1_ready),
    .valid     (out1_valid),
    .data      (out1_data),
    .cnt       (out1_cnt),
    .full      (full1)
  );
endmodule
